// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg: FSM state encoding and default width for cnt_period_ctrl (optional CNT_CTRL_DOWN_EN)
package cnt_ctrl_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/cnt_core.sv
// cnt_core: counter register with clear/load/enable, optional down count under CNT_CTRL_DOWN_EN
module cnt_core
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
`ifdef CNT_CTRL_DOWN_EN
  input  logic             dn,
`endif
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (load) q <= load_val;
`ifdef CNT_CTRL_DOWN_EN
    else if (en) q <= dn ? q - WIDTH'(1) : q + WIDTH'(1);
`else
    else if (en) q <= q + WIDTH'(1);
`endif
  end
endmodule

// File: rtl/cnt_period_ctrl.sv
// cnt_period_ctrl: start/stop interval timer FSM driving cnt_core; CNT_CTRL_DOWN_EN adds down-count mode
module cnt_period_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ZERO_AS_ONE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
`ifdef CNT_CTRL_DOWN_EN
  input  logic             down,
`endif
  input  logic [WIDTH-1:0] period_in,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);
  logic [1:0] state, state_nxt;
  logic [WIDTH-1:0] period_r, period_eff, load_val;
  logic mode_r, dn_r, dn_start, go, term, clr, load, en;
  assign period_eff = (ZERO_AS_ONE != 0 && period_in == '0) ? WIDTH'(1) : period_in;
  assign go = state == ST_IDLE && start && !stop;
`ifdef CNT_CTRL_DOWN_EN
  assign dn_start = down;
  always_ff @(posedge clk) begin
    if (rst) dn_r <= 1'b0;
    else if (go) dn_r <= down;
  end
`else
  assign dn_start = 1'b0;
  assign dn_r = 1'b0;
`endif
  assign term = dn_r ? count == '0 : count == period_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      period_r <= '0;
      mode_r   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= clr && state != ST_IDLE;
      if (go) begin
        period_r <= period_eff;
        mode_r   <= periodic;
      end
    end
  end
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = go ? ST_RUN : ST_IDLE;
      ST_RUN:   state_nxt = stop ? ST_PAUSE : (term && !mode_r) ? ST_IDLE : ST_RUN;
      ST_PAUSE: state_nxt = stop ? ST_IDLE : start ? ST_RUN : ST_PAUSE;
      default:  state_nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    busy     = state != ST_IDLE;
    tick     = state == ST_RUN && term;
    en       = state == ST_RUN && !stop && !term;
    load     = go || (state == ST_RUN && !stop && term && mode_r);
    clr      = (state == ST_RUN && !stop && term && !mode_r) || (state == ST_PAUSE && stop) || (state == ST_IDLE && !go);
    load_val = state == ST_IDLE ? (dn_start ? period_eff : '0) : (dn_r ? period_r : '0);
  end
  cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .load(load),
    .load_val(load_val),
    .en(en),
`ifdef CNT_CTRL_DOWN_EN
    .dn(dn_r),
`endif
    .q(count)
  );
endmodule

// File: tb/tb_cnt_period_ctrl.sv
// tb_cnt_period_ctrl: directed self-checking bench for cnt_period_ctrl (WIDTH=4, ZERO_AS_ONE=1)
module tb_cnt_period_ctrl;
  logic clk = 0, rst, start, stop, periodic;
  logic [3:0] period_in, count;
  logic busy, tick, done;
`ifdef CNT_CTRL_DOWN_EN
  logic down = 0;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cnt_period_ctrl #(.WIDTH(4), .ZERO_AS_ONE(1)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .periodic(periodic),
`ifdef CNT_CTRL_DOWN_EN
    .down(down),
`endif
    .period_in(period_in),
    .count(count),
    .busy(busy),
    .tick(tick),
    .done(done)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int c, input int b, input int t, input int d);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".busy"}, 32'(busy), b);
    chk({tag, ".tick"}, 32'(tick), t);
    chk({tag, ".done"}, 32'(done), d);
  endtask
  task automatic kick(input int p, input logic per);
    period_in = 4'(p);
    periodic = per;
    start = 1;
    step();
    start = 0;
  endtask
  task automatic abort_run();
    stop = 1;
    step();
    chk_all("abort_pause", count, 1, 0, 0);
    step();
    chk_all("abort_idle", 0, 0, 0, 1);
    stop = 0;
    step();
    chk_all("abort_after", 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1; start = 0; stop = 0; periodic = 0; period_in = 0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    rst = 0;
    step();
    chk_all("idle", 0, 0, 0, 0);
    stop = 1;
    step();
    stop = 0;
    chk_all("idle_stop", 0, 0, 0, 0);
    kick(5, 0);
    chk_all("os_start", 0, 1, 0, 0);
    period_in = 2;
    periodic = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all($sformatf("os_k%0d", k), k, 1, k == 5, 0);
    end
    step();
    chk_all("os_done", 0, 0, 0, 1);
    step();
    chk_all("os_after", 0, 0, 0, 0);
    kick(3, 1);
    periodic = 0;
    chk_all("per_start", 0, 1, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      step();
      chk_all($sformatf("per_c%0d", c), c % 4, 1, (c % 4) == 3, 0);
    end
    abort_run();
    kick(5, 0);
    step();
    step();
    chk_all("pr_cnt2", 2, 1, 0, 0);
    stop = 1;
    step();
    stop = 0;
    chk_all("pr_pause", 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("pr_hold%0d", i), 2, 1, 0, 0);
    end
    start = 1;
    period_in = 9;
    step();
    start = 0;
    chk_all("pr_resume", 2, 1, 0, 0);
    for (int k = 3; k <= 5; k++) begin
      step();
      chk_all($sformatf("pr_k%0d", k), k, 1, k == 5, 0);
    end
    step();
    chk_all("pr_done", 0, 0, 0, 1);
    start = 1; stop = 1; period_in = 5; periodic = 0;
    step();
    start = 0; stop = 0;
    chk_all("prio_idle", 0, 0, 0, 0);
    kick(5, 0);
    step();
    chk_all("prio_run1", 1, 1, 0, 0);
    start = 1; stop = 1;
    step();
    start = 0;
    chk_all("prio_run_pause", 1, 1, 0, 0);
    step();
    stop = 0;
    chk_all("prio_pause_abort", 0, 0, 0, 1);
    step();
    chk_all("prio_after", 0, 0, 0, 0);
    kick(1, 0);
    step();
    chk_all("term_tick", 1, 1, 1, 0);
    stop = 1;
    step();
    stop = 0;
    chk_all("term_stop", 1, 1, 0, 0);
    stop = 1;
    step();
    stop = 0;
    chk_all("term_abort", 0, 0, 0, 1);
    kick(9, 0);
    for (int k = 1; k <= 4; k++) step();
    chk_all("rst_mid_cnt4", 4, 1, 0, 0);
    rst = 1;
    step();
    rst = 0;
    chk_all("rst_mid", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("rst_after%0d", i), 0, 0, 0, 0);
    end
    kick(15, 1);
    for (int k = 1; k <= 15; k++) step();
    chk_all("wrap_15", 15, 1, 1, 0);
    step();
    chk_all("wrap_0", 0, 1, 0, 0);
    step();
    chk_all("wrap_1", 1, 1, 0, 0);
    abort_run();
    kick(0, 1);
    chk_all("zero_start", 0, 1, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk_all($sformatf("zero_c%0d", c), c % 2, 1, c % 2, 0);
    end
    abort_run();
`ifdef CNT_CTRL_DOWN_EN
    down = 1;
    kick(4, 0);
    down = 0;
    chk_all("dn_start", 4, 1, 0, 0);
    for (int k = 3; k >= 0; k--) begin
      step();
      chk_all($sformatf("dn_k%0d", k), k, 1, k == 0, 0);
    end
    step();
    chk_all("dn_done", 0, 0, 0, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnt_period_ctrl.md
Name: cnt_period_ctrl

Overview:
- Controller that sequences a synchronous-reset up-counter as a programmable interval timer.
- Accepts start/stop commands, latches a period and runs the counter in one-shot or periodic mode.
- Generates terminal-count and completion pulses for downstream logic.
- Sits between control logic or a testbench and the counter datapath (cnt_core).

Parameters:
- WIDTH, 4, counter and period width in bits.
- ZERO_AS_ONE, 1, if 1 a latched period of 0 is replaced by 1; if 0 a period of 0 ticks every cycle.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  command: begin run (IDLE) or resume (PAUSE)
- stop  in  1  command: pause (RUN) or abort (PAUSE)
- periodic  in  1  mode, sampled with start in IDLE: 1 = periodic, 0 = one-shot
- period_in  in  WIDTH  terminal count, sampled with start in IDLE
- count  out  WIDTH  current counter value
- busy  out  1  high in RUN and PAUSE
- tick  out  1  high while in RUN and count == period_r
- done  out  1  one-cycle pulse after one-shot completion or abort

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- rst high at an edge: state=IDLE; count, period_r, mode_r, done = 0. Outputs busy=0 and tick=0. rst overrides all commands, including mid-run.
- FSM states: IDLE, RUN, PAUSE.
- IDLE:
  - count held at 0.
  - start (with stop low) latches period_r <= period_in and mode_r <= periodic, then moves to RUN with count=0.
  - stop is ignored.
- RUN:
  - count increments by 1 every cycle.
  - When count == period_r, tick is high for that cycle. At the next edge, periodic mode sets count to 0 and stays in RUN; one-shot mode returns to IDLE, clears count and sets done=1 for one cycle.
  - stop moves to PAUSE with count frozen. A stop arriving on the terminal cycle wins: the state goes to PAUSE and count is unchanged.
  - start is ignored.
- PAUSE:
  - count is frozen and tick=0.
  - start resumes RUN at the next edge; period_r and mode_r are not re-latched.
  - stop aborts: go to IDLE, count=0, done=1 for one cycle.
- start and stop both high: stop has priority in every state.
- Latency:
  - start sampled at edge N gives busy=1, count=0 after N.
  - count=k after N+k; tick is high during the cycle after edge N+P.
  - Periodic tick spacing is P+1 cycles.
- Arithmetic: count is unsigned modulo 2^WIDTH. Wrap is governed by period_r; period_r = 2^WIDTH-1 is legal and wraps to 0.
- Changes on period_in or periodic outside the IDLE start cycle have no effect.

Optional Feature:
- Macro CNT_CTRL_DOWN_EN.
- Defined:
  - Adds input port down (1 bit), sampled with start in IDLE.
  - down=1: count loads period_r on start and decrements; the terminal condition is count == 0; the periodic reload value is period_r.
  - Tick spacing and done timing are identical to up mode.
- Undefined: the port is absent and the block counts up only.

Decomposition:
- Package cnt_ctrl_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
  - Default WIDTH constant.
- Sub-module cnt_core: WIDTH-bit register with synchronous rst, clr, load/load_val, en and (with the macro) dn inputs. The FSM in cnt_period_ctrl drives these inputs.

Test Plan:
- Reset then one-shot: rst high for 2 cycles, start with period_in=5 and periodic=0. Expect count 0..5, tick in the count=5 cycle, done pulse one cycle later, busy=0 afterwards.
- Periodic: period_in=3, periodic=1. Expect tick every 4 cycles for 5 periods and count wrapping 3→0; busy stays high.
- Pause/resume: stop at count=2 and hold 4 cycles. Expect count frozen at 2, busy=1, tick=0. Then start: expect count 3 on the next cycle and a tick at 5 for period 5.
- Abort and priority: start+stop together in IDLE gives no run. In PAUSE, stop gives IDLE, count=0, done pulse. In RUN, start+stop gives PAUSE.
- Reset mid-run: rst asserted at count=4 of period 9. Expect count=0, busy=0, tick=0, done=0 at the next edge, and no done pulse afterwards.
- Boundary: period_in=15 with WIDTH=4 wraps 15→0 in periodic mode. period_in=0 with ZERO_AS_ONE=1 gives tick every 2 cycles. With CNT_CTRL_DOWN_EN and down=1, period 4 counts 4,3,2,1,0 with tick at 0.
